// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-requester dmem arbiter: FSM encoding,
// requester IDs and the burst counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_IO  = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t ID_CPU = 1'b0;
  localparam req_id_t ID_IO  = 1'b1;

  // Wide enough for MAX_BURST up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins; on a tie the one
// not granted most recently wins. Bit 0 is the CPU, bit 1 is IO.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (&req_i) begin
      pick_o = (last_i == ID_IO) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port synchronous dmem between the CPU and the IO/display
// requester, with lockable bursts capped at MAX_BURST consecutive grants.
//
// state      | meaning
// ST_IDLE    | no owner, round-robin arbitration
// ST_OWN_CPU | CPU holds the lock, keeps the grant while burst_cnt < MAX_BURST
// ST_OWN_IO  | IO holds the lock, keeps the grant while burst_cnt < MAX_BURST
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_cpu,
  input  logic              req_io,
  input  logic              lock_cpu,
  input  logic              lock_io,
  input  logic              wren_cpu,
  input  logic              wren_io,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic [ADDR_W-1:0] addr_io,
  input  logic [DATA_W-1:0] wdata_cpu,
  input  logic [DATA_W-1:0] wdata_io,
  output logic              gnt_cpu,
  output logic              gnt_io,
  output logic              rvalid_cpu,
  output logic              rvalid_io,
  output logic [DATA_W-1:0] rdata_cpu,
  output logic [DATA_W-1:0] rdata_io,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

  arb_state_e        state_q;
  req_id_t           last_grant_q;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rv_cpu_q, rv_io_q;
  logic [DATA_W-1:0] rdata_cpu_q, rdata_io_q;

  logic [1:0] pick;
  logic       own_cpu, own_io;

  rr_pick2 u_pick (
    .req_i  ({req_io, req_cpu}),
    .last_i (last_grant_q),
    .pick_o (pick)
  );

  assign own_cpu = (state_q == ST_OWN_CPU) && req_cpu && (burst_cnt_q < MAX_B);
  assign own_io  = (state_q == ST_OWN_IO)  && req_io  && (burst_cnt_q < MAX_B);

  // An owner that drops its request or exhausts its burst falls straight
  // through to round-robin in the same cycle.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_io  = 1'b0;
    if (!reset) begin
      if (own_cpu) begin
        gnt_cpu = 1'b1;
      end else if (own_io) begin
        gnt_io = 1'b1;
      end else begin
        gnt_cpu = pick[0];
        gnt_io  = pick[1];
      end
    end
  end

  // With no grant the bus holds the last issued address/data.
  always_comb begin
    address_dmem = addr_q;
    data         = data_q;
    if (reset) begin
      address_dmem = '0;
      data         = '0;
    end else if (gnt_cpu) begin
      address_dmem = addr_cpu;
      data         = wdata_cpu;
    end else if (gnt_io) begin
      address_dmem = addr_io;
      data         = wdata_io;
    end
  end

  assign wren = (gnt_cpu & wren_cpu) | (gnt_io & wren_io);

  // Read responses are masked during reset so an in-flight read never shows.
  assign rvalid_cpu = rv_cpu_q & ~reset;
  assign rvalid_io  = rv_io_q  & ~reset;
  assign rdata_cpu  = reset ? '0 : (rv_cpu_q ? q_dmem : rdata_cpu_q);
  assign rdata_io   = reset ? '0 : (rv_io_q  ? q_dmem : rdata_io_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_IO;
      burst_cnt_q  <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rv_cpu_q     <= 1'b0;
      rv_io_q      <= 1'b0;
      rdata_cpu_q  <= '0;
      rdata_io_q   <= '0;
    end else begin
      addr_q   <= address_dmem;
      data_q   <= data;
      rv_cpu_q <= gnt_cpu & ~wren_cpu;
      rv_io_q  <= gnt_io & ~wren_io;
      if (rv_cpu_q) rdata_cpu_q <= q_dmem;
      if (rv_io_q)  rdata_io_q  <= q_dmem;

      if (gnt_cpu) begin
        last_grant_q <= ID_CPU;
        burst_cnt_q  <= own_cpu ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
        state_q      <= lock_cpu ? ST_OWN_CPU : ST_IDLE;
      end else if (gnt_io) begin
        last_grant_q <= ID_IO;
        burst_cnt_q  <= own_io ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
        state_q      <= lock_io ? ST_OWN_IO : ST_IDLE;
      end else begin
        burst_cnt_q <= '0;
        state_q     <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a reference arbitration
// model, a reference memory and a read-response scoreboard.
module tb_dmem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          req_cpu, req_io, lock_cpu, lock_io, wren_cpu, wren_io;
  logic [AW-1:0] addr_cpu, addr_io;
  logic [DW-1:0] wdata_cpu, wdata_io;
  logic          gnt_cpu, gnt_io, rvalid_cpu, rvalid_io;
  logic [DW-1:0] rdata_cpu, rdata_io;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data;
  logic          wren;
  logic [DW-1:0] q_dmem;

  logic [DW-1:0] dmem [0:(1<<AW)-1];

  always @(posedge clock) begin
    if (wren) dmem[address_dmem] <= data;
    q_dmem <= dmem[address_dmem];
  end

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .req_cpu(req_cpu), .req_io(req_io),
    .lock_cpu(lock_cpu), .lock_io(lock_io),
    .wren_cpu(wren_cpu), .wren_io(wren_io),
    .addr_cpu(addr_cpu), .addr_io(addr_io),
    .wdata_cpu(wdata_cpu), .wdata_io(wdata_io),
    .gnt_cpu(gnt_cpu), .gnt_io(gnt_io),
    .rvalid_cpu(rvalid_cpu), .rvalid_io(rvalid_io),
    .rdata_cpu(rdata_cpu), .rdata_io(rdata_io),
    .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem)
  );

  typedef struct packed {
    logic          who;
    logic [DW-1:0] val;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] ref_mem [0:31];

  int            m_state, m_cnt;
  logic          m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd_cpu, m_rd_io;
  int            wait_c, wait_i;
  int            checks = 0;
  int            errors = 0;

  logic          obs_gc, obs_gi, obs_rvc, obs_rvi;
  logic [DW-1:0] obs_rdi;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven, check outputs mid-cycle, advance the model.
  task automatic step();
    rd_t  r;
    logic mg_c, mg_i, exp_wr;
    @(negedge clock);
    obs_gc  = gnt_cpu;
    obs_gi  = gnt_io;
    obs_rvc = rvalid_cpu;
    obs_rvi = rvalid_io;
    obs_rdi = rdata_io;
    if (reset) begin
      check("rst_gnt_cpu", 32'(gnt_cpu), 0);
      check("rst_gnt_io", 32'(gnt_io), 0);
      check("rst_rvalid_cpu", 32'(rvalid_cpu), 0);
      check("rst_rvalid_io", 32'(rvalid_io), 0);
      check("rst_rdata_cpu", rdata_cpu, 0);
      check("rst_rdata_io", rdata_io, 0);
      check("rst_wren", 32'(wren), 0);
      check("rst_addr", 32'(address_dmem), 0);
      check("rst_data", data, 0);
      m_state = 0; m_last = 1'b1; m_cnt = 0;
      m_addr = '0; m_data = '0; m_rd_cpu = '0; m_rd_io = '0;
      exp_q.delete();
      wait_c = 0; wait_i = 0;
    end else begin
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.who) m_rd_io = r.val;
        else       m_rd_cpu = r.val;
        check("rvalid_cpu", 32'(rvalid_cpu), 32'(!r.who));
        check("rvalid_io", 32'(rvalid_io), 32'(r.who));
      end else begin
        check("rvalid_cpu_idle", 32'(rvalid_cpu), 0);
        check("rvalid_io_idle", 32'(rvalid_io), 0);
      end
      check("rdata_cpu", rdata_cpu, m_rd_cpu);
      check("rdata_io", rdata_io, m_rd_io);

      mg_c = 1'b0; mg_i = 1'b0;
      if (m_state == 1 && req_cpu && m_cnt < MAXB)     mg_c = 1'b1;
      else if (m_state == 2 && req_io && m_cnt < MAXB) mg_i = 1'b1;
      else if (req_cpu && req_io) begin
        if (m_last) mg_c = 1'b1;
        else        mg_i = 1'b1;
      end else begin
        mg_c = req_cpu;
        mg_i = req_io;
      end
      check("gnt_cpu", 32'(gnt_cpu), 32'(mg_c));
      check("gnt_io", 32'(gnt_io), 32'(mg_i));

      exp_wr = 1'b0;
      if (mg_c) begin
        m_addr = addr_cpu; m_data = wdata_cpu; exp_wr = wren_cpu;
      end else if (mg_i) begin
        m_addr = addr_io; m_data = wdata_io; exp_wr = wren_io;
      end
      check("wren", 32'(wren), 32'(exp_wr));
      check("address", 32'(address_dmem), 32'(m_addr));
      check("data", data, m_data);

      if (mg_c || mg_i) begin
        if (exp_wr) ref_mem[m_addr[4:0]] = m_data;
        else begin
          r.who = mg_i;
          r.val = ref_mem[m_addr[4:0]];
          exp_q.push_back(r);
        end
      end

      if (gnt_cpu) begin
        check("starve_cpu", 32'(wait_c <= MAXB), 1);
        wait_c = 0;
      end else if (req_cpu) wait_c++;
      else wait_c = 0;
      if (gnt_io) begin
        check("starve_io", 32'(wait_i <= MAXB), 1);
        wait_i = 0;
      end else if (req_io) wait_i++;
      else wait_i = 0;

      if (mg_c) begin
        m_cnt   = (m_state == 1 && m_cnt < MAXB) ? m_cnt + 1 : 1;
        m_last  = 1'b0;
        m_state = lock_cpu ? 1 : 0;
      end else if (mg_i) begin
        m_cnt   = (m_state == 2 && m_cnt < MAXB) ? m_cnt + 1 : 1;
        m_last  = 1'b1;
        m_state = lock_io ? 2 : 0;
      end else begin
        m_cnt   = 0;
        m_state = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_cpu = 0; req_io = 0; lock_cpu = 0; lock_io = 0;
    wren_cpu = 0; wren_io = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    addr_cpu = '0; addr_io = '0; wdata_cpu = '0; wdata_io = '0;
    step();
    req_cpu = 1'b1;
    step();
    step();
    reset = 1'b0;
    req_cpu = 1'b0;
    step();

    // preload every address used below so no read returns unknown data
    for (int a = 0; a <= 16; a++) begin
      req_cpu = 1'b1; wren_cpu = 1'b1;
      addr_cpu = AW'(a); wdata_cpu = $urandom;
      step();
    end
    idle_inputs();

    // contention, reads, no lock: CPU, IO, CPU, IO after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_cpu = 1'b1; req_io = 1'b1; addr_cpu = 12'd3; addr_io = 12'd5;
    for (int k = 0; k < 4; k++) begin
      step();
      check("alt_cpu", 32'(obs_gc), 32'(k % 2 == 0));
      check("alt_io", 32'(obs_gi), 32'(k % 2 == 1));
    end
    idle_inputs();
    step();

    // CPU write then IO read of the same word
    req_cpu = 1'b1; wren_cpu = 1'b1; addr_cpu = 12'h010; wdata_cpu = 32'hDEADBEEF;
    step();
    idle_inputs();
    req_io = 1'b1; addr_io = 12'h010;
    step();
    check("raw_gnt_io", 32'(obs_gi), 1);
    idle_inputs();
    step();
    check("raw_rvalid_io", 32'(obs_rvi), 1);
    check("raw_rdata_io", obs_rdi, 32'hDEADBEEF);

    // IO locked burst with CPU waiting: 4 IO grants then CPU
    step();
    req_io = 1'b1; lock_io = 1'b1; addr_io = 12'd2;
    step();
    check("burst_first_io", 32'(obs_gi), 1);
    req_cpu = 1'b1; addr_cpu = 12'd4;
    for (int k = 0; k < 4; k++) begin
      step();
      check("burst_io", 32'(obs_gi), 32'(k < 3));
      check("burst_cpu", 32'(obs_gc), 32'(k == 3));
    end
    idle_inputs();
    step();

    // IO locked alone: never loses the grant
    req_io = 1'b1; lock_io = 1'b1; addr_io = 12'd9;
    for (int k = 0; k < 10; k++) begin
      step();
      check("solo_io", 32'(obs_gi), 1);
    end
    idle_inputs();
    step();

    // reset right behind a CPU read swallows the response
    req_cpu = 1'b1; addr_cpu = 12'd7;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("rst_read_rvalid", 32'(obs_rvc), 0);

    for (int n = 0; n < 10000; n++) begin
      req_cpu   = ($urandom_range(9, 0) < 7);
      req_io    = ($urandom_range(9, 0) < 7);
      lock_cpu  = ($urandom_range(9, 0) < 4);
      lock_io   = ($urandom_range(9, 0) < 4);
      wren_cpu  = ($urandom_range(9, 0) < 4);
      wren_io   = ($urandom_range(9, 0) < 4);
      addr_cpu  = AW'($urandom_range(16, 0));
      addr_io   = AW'($urandom_range(16, 0));
      wdata_cpu = $urandom;
      wdata_io  = $urandom;
      step();
    end
    idle_inputs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
